// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state enum and default widths for the column dot-product controller
package ctrl_pkg;
  localparam int DATA_W   = 32;
  localparam int VLEN_DEF = 16;
  typedef enum logic {RUN, DONE} state_e;
endpackage

// File: rtl/ctrl_mac.sv
// ctrl_mac: multiply-accumulate with group clear; CTRL_SAT_EN selects saturating instead of wrapping arithmetic
module ctrl_mac #(
  parameter int DATA_W = ctrl_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              en,
  input  logic              clr,
  input  logic              last,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);
  logic [DATA_W-1:0] acc_q, acc_d, base;
`ifdef CTRL_SAT_EN
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   prod_s;
  logic [DATA_W:0]     sum_w;
  // saturating product and sum; the accumulator restarts at the first element of a group
  always_comb begin
    base   = clr ? '0 : acc_q;
    prod   = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    prod_s = |prod[2*DATA_W-1:DATA_W] ? '1 : prod[DATA_W-1:0];
    sum_w  = {1'b0, base} + {1'b0, prod_s};
    sum    = sum_w[DATA_W] ? '1 : sum_w[DATA_W-1:0];
    acc_d  = en ? (last ? '0 : sum) : acc_q;
  end
`else
  logic [DATA_W-1:0] prod;
  // wrapping product and sum; the accumulator restarts at the first element of a group
  always_comb begin
    base  = clr ? '0 : acc_q;
    prod  = a * b;
    sum   = base + prod;
    acc_d = en ? (last ? '0 : sum) : acc_q;
  end
`endif
  // accumulator register, cleared once a group's result has been taken
  always_ff @(posedge Clk) begin
    if (Rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
endmodule

// File: rtl/control.sv
// control: streams a column against a cyclically reused v vector, emitting one dot product per group; CTRL_SAT_EN enables saturating arithmetic
module control #(
  parameter int VLEN   = ctrl_pkg::VLEN_DEF,
  parameter int DATA_W = ctrl_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic [DATA_W-1:0] v_values_base,
  input  logic [DATA_W-1:0] wdata_col_base,
  output logic [DATA_W-1:0] addr1,
  output logic [DATA_W-1:0] addr2,
  input  logic [DATA_W-1:0] dataIn1,
  input  logic [DATA_W-1:0] dataIn2,
  input  logic              Rst,
  input  logic [DATA_W-1:0] csize,
  input  logic              RD,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              done
);
  import ctrl_pkg::*;
  localparam int KW = VLEN > 1 ? $clog2(VLEN) : 1;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] idx_q, idx_d, result_q, result_d, sum;
  logic [KW-1:0]     k_q, k_d;
  logic              valid_q, valid_d, step, last_el, last_grp;
  assign addr1        = wdata_col_base + idx_q;
  assign addr2        = v_values_base + DATA_W'(k_q);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign done         = state_q == DONE;
  ctrl_mac #(.DATA_W(DATA_W)) u_mac (
    .Clk (Clk),
    .Rst (Rst),
    .en  (step),
    .clr (k_q == '0),
    .last(last_grp),
    .a   (dataIn1),
    .b   (dataIn2),
    .sum (sum)
  );
  // one element per enabled cycle; counters freeze on the final element so the addresses hold
  always_comb begin
    step     = state_q == RUN && RD;
    last_el  = idx_q == csize - 1'b1;
    last_grp = k_q == KW'(VLEN - 1) || last_el;
    state_d  = step && last_el ? DONE : state_q;
    idx_d    = step && !last_el ? idx_q + 1'b1 : idx_q;
    k_d      = step && !last_el ? (k_q == KW'(VLEN - 1) ? '0 : k_q + 1'b1) : k_q;
    result_d = step && last_grp ? sum : result_q;
    valid_d  = step && last_grp;
  end
  // state and counter registers; an empty column goes straight to DONE out of reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= csize != '0 ? RUN : DONE;
      idx_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      k_q      <= k_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end
endmodule

// File: tb/tb_control.sv
// tb_control: directed and randomized checks of control against an arithmetic reference model
module tb_control;
  localparam int VLEN = 16;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        RD = 1'b0;
  logic [31:0] v_values_base, wdata_col_base, addr1, addr2, dataIn1, dataIn2, csize, result;
  logic        result_valid, done;
  logic [31:0] mem [0:1023];
  int          vb = 2, cb = 180;
  int          n_chk = 0, n_fail = 0;
  int          pulses, first_cyc;
  logic [31:0] first_res, last_res;
  int          vvals [16] = '{25, 71, 63, 46, 46, 19, 30, 78, 0, 44, 54, 35, 97, 59, 72, 80};
  int          cvals [16] = '{13, 10, 3, 9, 4, 7, 8, 5, 9, 10, 9, 1, 5, 2, 5, 2};

  always #5 Clk = ~Clk;
  assign v_values_base  = 32'(vb);
  assign wdata_col_base = 32'(cb);
  assign dataIn1 = mem[addr1[9:0]];
  assign dataIn2 = mem[addr2[9:0]];

  control #(.VLEN(VLEN), .DATA_W(32)) dut (
    .Clk(Clk), .v_values_base(v_values_base), .wdata_col_base(wdata_col_base),
    .addr1(addr1), .addr2(addr2), .dataIn1(dataIn1), .dataIn2(dataIn2),
    .Rst(Rst), .csize(csize), .RD(RD), .result(result),
    .result_valid(result_valid), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // dot product of column elements [a,b) with v reused cyclically, wrapped or saturated at 32 bits
  function automatic logic [31:0] gsum(input int a, input int b);
    logic [63:0] acc = 0, p;
    for (int i = a; i < b; i++) begin
      p = 64'(mem[cb + i]) * 64'(mem[vb + i % VLEN]);
`ifdef CTRL_SAT_EN
      if (p > 64'hFFFF_FFFF) p = 64'hFFFF_FFFF;
      acc = acc + p;
      if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
`else
      acc = (acc + p) & 64'hFFFF_FFFF;
`endif
    end
    return acc[31:0];
  endfunction

  // reset with column length n, then run for a fixed number of cycles, checking every cycle
  task automatic run(input int n, input int stall_at, input int stall_len, input bit rnd_rd, input int cycles);
    int  m = 0, eff;
    bit  rd, pulse;
    pulses = 0; first_cyc = -1; first_res = 'x; last_res = 'x;
    csize = 32'(n); Rst = 1'b1; RD = 1'b1;
    @(posedge Clk); #1;
    chk("rst_addr1", addr1, 32'(cb));
    chk("rst_addr2", addr2, 32'(vb));
    chk("rst_valid", {31'b0, result_valid}, 0);
    chk("rst_result", result, 0);
    chk("rst_done", {31'b0, done}, (n == 0) ? 1 : 0);
    Rst = 1'b0;
    for (int e = 1; e <= cycles; e++) begin
      rd = rnd_rd ? ($urandom_range(0, 3) != 0) : !(e > stall_at && e <= stall_at + stall_len);
      RD = rd;
      @(posedge Clk); #1;
      pulse = 0;
      if (rd && m < n) begin
        m++;
        pulse = (m % VLEN == 0) || (m == n);
      end
      chk("valid", {31'b0, result_valid}, {31'b0, pulse});
      if (pulse) begin
        chk("result", result, gsum(((m - 1) / VLEN) * VLEN, m));
        pulses++;
        if (first_cyc < 0) begin first_cyc = e + 1; first_res = result; end
        last_res = result;
      end
      chk("done", {31'b0, done}, {31'b0, m == n});
      eff = (n == 0) ? 0 : ((m < n - 1) ? m : n - 1);
      chk("addr1", addr1, 32'(cb + eff));
      chk("addr2", addr2, 32'(vb + eff % VLEN));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom_range(0, 255);
    for (int i = 0; i < 16; i++) begin mem[2 + i] = 32'(vvals[i]); mem[180 + i] = 32'(cvals[i]); end
    mem[356] = 9; mem[357] = 12; mem[358] = 13;
    csize = 16;
    // basic 16-element column
    run(16, 0, 0, 0, 20);
    chk("basic_result", first_res, 4669);
    chk("basic_cycle", 32'(first_cyc), 17);
    chk("basic_pulses", 32'(pulses), 1);
    // long column with a partial final group
    run(179, 0, 0, 0, 182);
    chk("long_pulses", 32'(pulses), 12);
    chk("long_last", last_res, 1896);
    // five-cycle stall mid-group
    run(16, 7, 5, 0, 25);
    chk("stall_result", first_res, 4669);
    chk("stall_cycle", 32'(first_cyc), 22);
    // reset part-way through, then a full rerun
    run(16, 0, 0, 0, 7);
    run(16, 0, 0, 0, 20);
    chk("rerun_result", first_res, 4669);
    // empty column
    run(0, 0, 0, 0, 10);
    chk("empty_pulses", 32'(pulses), 0);
    // overflowing products
    vb = 600; cb = 700;
    for (int i = 0; i < 16; i++) begin mem[600 + i] = 32'h10000; mem[700 + i] = 32'h10000; end
    run(16, 0, 0, 0, 18);
`ifdef CTRL_SAT_EN
    chk("ovf_result", first_res, 32'hFFFF_FFFF);
`else
    chk("ovf_result", first_res, 32'h0);
`endif
    // random data, length and run enable
    for (int t = 0; t < 4; t++) begin
      int n;
      vb = 600; cb = 640;
      for (int i = 0; i < 16; i++) mem[600 + i] = (t % 2) ? $urandom : $urandom_range(0, 1000);
      for (int i = 0; i < 300; i++) mem[640 + i] = (t % 2) ? $urandom : $urandom_range(0, 1000);
      n = $urandom_range(1, 200);
      run(n, 0, 0, 1, 2 * n + 60);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
